uart_tx_frame: RTL and testbench

- Serial transmit stage directly downstream of the echo/control block.
- Accepts a byte on TX_DATA when TX_EN is strobed and serialises it onto UART_TXD as an asynchronous UART frame: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
- Reports idle/busy on TX_STATUS, which the control block uses to decide when to strobe TX_EN.

---
 rtl/uart_tx_frame.sv | 81 ++++++++
 tb/tb_uart_tx_frame.sv | 137 +++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: serialises a byte as an async UART frame (start, 8 data LSB first, optional parity, 1-2 stop bits)
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] TX_DATA,
  input  logic       TX_EN,
  output logic       TX_STATUS,
  output logic       UART_TXD
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PAR = 3'd3, STOP = 3'd4;
  logic [2:0] state;
  logic [BW-1:0] baud;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic par_bit;
  logic tc;
  assign tc = baud == BW'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      TX_STATUS <= 1'b1;
      UART_TXD <= 1'b1;
      bit_cnt <= '0;
      baud <= '0;
      shift <= '0;
      par_bit <= 1'b0;
    end else if (state == IDLE) begin
      if (TX_EN) begin
        shift <= TX_DATA;
        par_bit <= PARITY == 1 ? ~^TX_DATA : ^TX_DATA;
        state <= START;
        UART_TXD <= 1'b0;
        TX_STATUS <= 1'b0;
        baud <= '0;
      end
    end else begin
      baud <= tc ? '0 : baud + 1'b1;
      if (tc) begin
        case (state)
          START: begin
            UART_TXD <= shift[0];
            shift <= shift >> 1;
            bit_cnt <= '0;
            state <= DATA;
          end
          DATA: begin
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
              state <= PARITY != 0 ? PAR : STOP;
              UART_TXD <= PARITY != 0 ? par_bit : 1'b1;
            end else begin
              UART_TXD <= shift[0];
              shift <= shift >> 1;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          PAR: begin
            state <= STOP;
            UART_TXD <= 1'b1;
          end
          STOP: begin
            // bit_cnt is reused here to count stop bits
            if (bit_cnt == 3'(STOP_BITS - 1)) begin
              state <= IDLE;
              TX_STATUS <= 1'b1;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: three parameterisations driven in parallel, checked every cycle against a frame-level model
module tb_uart_tx_frame;
  localparam int C = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx_en = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic txd [3];
  logic st [3];
  logic chk = 1'b0;
  int checks = 0;
  int errors = 0;
  int rem [3];
  int pos [3];
  logic [7:0] dat [3];

  always #5 clk = ~clk;

  uart_tx_frame #(.CLKS_PER_BIT(C), .PARITY(0), .STOP_BITS(1)) d0 (
    .clk(clk), .rst(rst), .TX_DATA(tx_data), .TX_EN(tx_en), .TX_STATUS(st[0]), .UART_TXD(txd[0]));
  uart_tx_frame #(.CLKS_PER_BIT(C), .PARITY(2), .STOP_BITS(1)) d1 (
    .clk(clk), .rst(rst), .TX_DATA(tx_data), .TX_EN(tx_en), .TX_STATUS(st[1]), .UART_TXD(txd[1]));
  uart_tx_frame #(.CLKS_PER_BIT(C), .PARITY(1), .STOP_BITS(2)) d2 (
    .clk(clk), .rst(rst), .TX_DATA(tx_data), .TX_EN(tx_en), .TX_STATUS(st[2]), .UART_TXD(txd[2]));

  function automatic int par_of(input int k);
    return k == 0 ? 0 : (k == 1 ? 2 : 1);
  endfunction

  function automatic int stop_of(input int k);
    return k == 2 ? 2 : 1;
  endfunction

  function automatic int flen(input int k);
    return (9 + (par_of(k) != 0 ? 1 : 0) + stop_of(k)) * C;
  endfunction

  // Line level for bit slot i of a frame carrying d
  function automatic logic fbit(input logic [7:0] d, input int k, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return d[i-1];
    if (i == 9 && par_of(k) != 0) return par_of(k) == 1 ? ~^d : ^d;
    return 1'b1;
  endfunction

  initial for (int k = 0; k < 3; k++) begin
    rem[k] = 0;
    pos[k] = 0;
    dat[k] = 8'h00;
  end

  always @(posedge clk)
    for (int k = 0; k < 3; k++) begin
      if (rst) rem[k] <= 0;
      else if (rem[k] == 0 && tx_en) begin
        dat[k] <= tx_data;
        pos[k] <= 0;
        rem[k] <= flen(k);
      end else if (rem[k] > 0) begin
        rem[k] <= rem[k] - 1;
        pos[k] <= pos[k] + 1;
      end
    end

  logic exp_txd, exp_st;
  always @(negedge clk)
    if (chk)
      for (int k = 0; k < 3; k++) begin
        exp_txd = rem[k] == 0 ? 1'b1 : fbit(dat[k], k, pos[k] / C);
        exp_st = rem[k] == 0;
        checks++;
        assert (txd[k] === exp_txd) else begin
          errors++;
          $error("FAIL txd%0d t=%0t observed=%b expected=%b", k, $time, txd[k], exp_txd);
        end
        checks++;
        assert (st[k] === exp_st) else begin
          errors++;
          $error("FAIL status%0d t=%0t observed=%b expected=%b", k, $time, st[k], exp_st);
        end
      end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [7:0] d);
    tx_data = d;
    tx_en = 1'b1;
    cyc(1);
    tx_en = 1'b0;
  endtask

  initial begin
    tx_en = 1'b1;
    cyc(1);
    chk = 1'b1;
    cyc(2);
    rst = 1'b0;
    tx_en = 1'b0;
    cyc(3);
    pulse(8'h55);
    cyc(50);
    pulse(8'h07);
    cyc(50);
    pulse(8'hA3);
    cyc(9);
    pulse(8'hFF);
    cyc(50);
    tx_data = 8'h80;
    tx_en = 1'b1;
    cyc(150);
    tx_en = 1'b0;
    cyc(50);
    pulse(8'h00);
    cyc(15);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(3);
    pulse(8'h3C);
    cyc(55);
    pulse(8'hFF);
    cyc(55);
    for (int i = 0; i < 400; i++) begin
      tx_data = 8'($urandom);
      tx_en = $urandom_range(0, 7) == 0;
      rst = $urandom_range(0, 149) == 0;
      cyc(1);
    end
    tx_en = 1'b0;
    rst = 1'b0;
    cyc(60);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
